// File: rtl/cmp_rs.sv
// Compare reservation station: holds branch-compare ops until both operands are valid.
// Optional macro CMP_RS_WAKEUP_BYPASS_EN lets a CDB wakeup issue in the same cycle.
module cmp_rs #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              load,
  input  logic [2:0]                        in_op,
  input  logic [31:0]                       in_r1,
  input  logic [31:0]                       in_r2,
  input  logic                              in_v1,
  input  logic                              in_v2,
  input  logic [TAG_W-1:0]                  in_q1,
  input  logic [TAG_W-1:0]                  in_q2,
  input  logic [TAG_W-1:0]                  in_tag,
  input  logic                              cdb_valid,
  input  logic [TAG_W-1:0]                  cdb_tag,
  input  logic [31:0]                       cdb_data,
  output logic [SIZE-1:0][TAG_W+66:0]       data,
  output logic [SIZE-1:0]                   ready,
  output logic                              full,
  output logic [$clog2(SIZE):0]             count
);

  localparam int unsigned CNT_W = $clog2(SIZE) + 1;

  logic [SIZE-1:0]             valid_q, valid_d;
  logic [SIZE-1:0]             v1_q, v1_d, v2_q, v2_d;
  logic [SIZE-1:0][2:0]        op_q, op_d;
  logic [SIZE-1:0][31:0]       r1_q, r1_d, r2_q, r2_d;
  logic [SIZE-1:0][TAG_W-1:0]  q1_q, q1_d, q2_q, q2_d, tag_q, tag_d;

  logic [SIZE-1:0]             hit1, hit2;
  logic [SIZE-1:0]             alloc_oh;
  logic                        seen_free;
  logic                        do_load;
  logic                        in_hit1, in_hit2;

  // CDB match for waiting operands of occupied entries
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      hit1[i] = valid_q[i] & ~v1_q[i] & cdb_valid & (q1_q[i] == cdb_tag);
      hit2[i] = valid_q[i] & ~v2_q[i] & cdb_valid & (q2_q[i] == cdb_tag);
    end
  end

  // Issue select and compare-unit payload
  always_comb begin
    ready = '0;
    data  = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
`ifdef CMP_RS_WAKEUP_BYPASS_EN
      ready[i] = valid_q[i] & (v1_q[i] | hit1[i]) & (v2_q[i] | hit2[i]);
      data[i]  = {op_q[i], hit1[i] ? cdb_data : r1_q[i],
                  hit2[i] ? cdb_data : r2_q[i], tag_q[i]};
`else
      ready[i] = valid_q[i] & v1_q[i] & v2_q[i];
      data[i]  = {op_q[i], r1_q[i], r2_q[i], tag_q[i]};
`endif
    end
  end

  // Occupancy from registered valid bits only
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      count = count + CNT_W'(valid_q[i]);
    end
    full = (count == CNT_W'(SIZE));
  end

  // Lowest-index free slot; slots issuing this cycle are still occupied
  always_comb begin
    alloc_oh  = '0;
    seen_free = 1'b0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (!valid_q[i] && !seen_free) begin
        alloc_oh[i] = 1'b1;
        seen_free   = 1'b1;
      end
    end
  end

  assign do_load = load & ~full;
  assign in_hit1 = ~in_v1 & cdb_valid & (in_q1 == cdb_tag);
  assign in_hit2 = ~in_v2 & cdb_valid & (in_q2 == cdb_tag);

  // Next state: issue frees, wakeup latches, dispatch writes, flush clears
  always_comb begin
    valid_d = valid_q & ~ready;
    v1_d    = v1_q;
    v2_d    = v2_q;
    op_d    = op_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    q1_d    = q1_q;
    q2_d    = q2_q;
    tag_d   = tag_q;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (hit1[i]) begin
        v1_d[i] = 1'b1;
        r1_d[i] = cdb_data;
      end
      if (hit2[i]) begin
        v2_d[i] = 1'b1;
        r2_d[i] = cdb_data;
      end
      if (do_load && alloc_oh[i]) begin
        valid_d[i] = 1'b1;
        op_d[i]    = in_op;
        tag_d[i]   = in_tag;
        q1_d[i]    = in_q1;
        q2_d[i]    = in_q2;
        v1_d[i]    = in_v1 | in_hit1;
        v2_d[i]    = in_v2 | in_hit2;
        r1_d[i]    = in_v1 ? in_r1 : cdb_data;
        r2_d[i]    = in_v2 ? in_r2 : cdb_data;
      end
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
    end else begin
      valid_q <= valid_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
    end
  end

  // Payload needs no reset: it is only observed behind valid
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    r1_q  <= r1_d;
    r2_q  <= r2_d;
    q1_q  <= q1_d;
    q2_q  <= q2_d;
    tag_q <= tag_d;
  end

endmodule

// File: tb/tb_cmp_rs.sv
// Self-checking bench for cmp_rs: directed scenarios then random traffic vs. an entry-list model.
module tb_cmp_rs;
  localparam int unsigned SIZE  = 8;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned EW    = TAG_W + 67;
`ifdef CMP_RS_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk, rst, flush, load;
  logic [2:0] in_op;
  logic [31:0] in_r1, in_r2, cdb_data;
  logic in_v1, in_v2, cdb_valid;
  logic [TAG_W-1:0] in_q1, in_q2, in_tag, cdb_tag;
  logic [SIZE-1:0][EW-1:0] data;
  logic [SIZE-1:0] ready;
  logic full;
  logic [$clog2(SIZE):0] count;

  cmp_rs #(.SIZE(SIZE), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .load(load), .in_op(in_op),
    .in_r1(in_r1), .in_r2(in_r2), .in_v1(in_v1), .in_v2(in_v2),
    .in_q1(in_q1), .in_q2(in_q2), .in_tag(in_tag), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .data(data), .ready(ready),
    .full(full), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit valid; bit [2:0] op; bit [31:0] r1; bit [31:0] r2;
    bit v1; bit v2; bit [TAG_W-1:0] q1; bit [TAG_W-1:0] q2; bit [TAG_W-1:0] tag;
  } ent_t;

  ent_t m [SIZE];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic bit bus_hit(input bit v, input bit [TAG_W-1:0] q);
    return !v && cdb_valid && (q == cdb_tag);
  endfunction

  function automatic bit m_ready(input int i);
    return m[i].valid && (m[i].v1 || (BYP && bus_hit(m[i].v1, m[i].q1)))
                      && (m[i].v2 || (BYP && bus_hit(m[i].v2, m[i].q2)));
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < SIZE; i++) if (m[i].valid) c++;
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < SIZE; i++) m[i] = '0;
  endtask

  task automatic check_outputs();
    logic [SIZE-1:0] er;
    int c;
    er = '0;
    for (int i = 0; i < SIZE; i++) er[i] = m_ready(i);
    c = m_count();
    chk("ready", EW'(ready), EW'(er));
    chk("count", EW'(count), EW'(c));
    chk("full", EW'(full), EW'(c == SIZE));
    for (int i = 0; i < SIZE; i++) begin
      if (m[i].valid) begin
        chk($sformatf("data%0d.op", i), EW'(data[i][EW-1 -: 3]), EW'(m[i].op));
        chk($sformatf("data%0d.tag", i), EW'(data[i][TAG_W-1:0]), EW'(m[i].tag));
      end
      if (er[i]) begin
        chk($sformatf("data%0d.r1", i), EW'(data[i][EW-4 -: 32]),
            EW'(m[i].v1 ? m[i].r1 : cdb_data));
        chk($sformatf("data%0d.r2", i), EW'(data[i][EW-36 -: 32]),
            EW'(m[i].v2 ? m[i].r2 : cdb_data));
      end
    end
  endtask

  // Apply one clock edge to the model using the inputs held across it
  task automatic model_clock();
    ent_t nx [SIZE];
    int slot = -1;
    for (int i = 0; i < SIZE; i++) if (!m[i].valid && slot < 0) slot = i;
    for (int i = 0; i < SIZE; i++) begin
      nx[i] = m[i];
      if (m_ready(i)) nx[i].valid = 1'b0;
      else if (m[i].valid) begin
        if (bus_hit(m[i].v1, m[i].q1)) begin nx[i].v1 = 1'b1; nx[i].r1 = cdb_data; end
        if (bus_hit(m[i].v2, m[i].q2)) begin nx[i].v2 = 1'b1; nx[i].r2 = cdb_data; end
      end
    end
    if (load && slot >= 0) begin
      nx[slot].valid = 1'b1; nx[slot].op = in_op; nx[slot].tag = in_tag;
      nx[slot].q1 = in_q1; nx[slot].q2 = in_q2;
      nx[slot].v1 = in_v1 || bus_hit(in_v1, in_q1);
      nx[slot].v2 = in_v2 || bus_hit(in_v2, in_q2);
      nx[slot].r1 = in_v1 ? in_r1 : cdb_data;
      nx[slot].r2 = in_v2 ? in_r2 : cdb_data;
    end
    if (flush) for (int i = 0; i < SIZE; i++) nx[i].valid = 1'b0;
    for (int i = 0; i < SIZE; i++) m[i] = nx[i];
  endtask

  task automatic step();
    check_outputs();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic drive_load(input bit ld, input bit [2:0] op, input bit [31:0] r1, input bit v1,
                            input bit [TAG_W-1:0] q1, input bit [31:0] r2, input bit v2,
                            input bit [TAG_W-1:0] q2, input bit [TAG_W-1:0] tag);
    load = ld; in_op = op; in_r1 = r1; in_v1 = v1; in_q1 = q1;
    in_r2 = r2; in_v2 = v2; in_q2 = q2; in_tag = tag;
  endtask

  task automatic drive_cdb(input bit v, input bit [TAG_W-1:0] t, input bit [31:0] d);
    cdb_valid = v; cdb_tag = t; cdb_data = d;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    drive_load(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_cdb(0, 0, 0);
    m_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Both operands valid at dispatch: issue next cycle, then free
    drive_load(1, 3'd0, 32'd5, 1, 0, 32'd5, 1, 0, 4'd3);
    step();
    drive_load(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("beq_ready0", EW'(ready), EW'(8'h01));
    chk("beq_tag0", EW'(data[0][TAG_W-1:0]), EW'(4'd3));
    step();
    step();

    // r1 pending on tag 7, broadcast two cycles later
    drive_load(1, 3'd1, 0, 0, 4'd7, 32'd9, 1, 0, 4'd5);
    step();
    drive_load(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive_cdb(1, 4'd7, 32'h10);
    step();
    drive_cdb(0, 0, 0);
    step();
    step();

    // Fill all slots, reject a ninth load, wake slot 4 and refill it
    for (int i = 0; i < SIZE; i++) begin
      drive_load(1, 3'(i), 0, 0, 4'(i + 8), 32'(i), 1, 0, 4'(i));
      step();
    end
    drive_load(1, 3'd7, 0, 0, 4'd1, 0, 1, 0, 4'd9);
    step();
    drive_load(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_cdb(1, 4'd12, 32'h44);
    step();
    drive_cdb(0, 0, 0);
    step();
    drive_load(1, 3'd5, 0, 0, 4'd1, 32'd1, 1, 0, 4'd11);
    step();
    drive_load(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("refill_slot4_tag", EW'(data[4][TAG_W-1:0]), EW'(4'd11));
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;

    // Dispatch coinciding with its producer's broadcast
    drive_load(1, 3'd0, 0, 0, 4'd2, 32'hAB, 1, 0, 4'd1);
    drive_cdb(1, 4'd2, 32'hAB);
    step();
    drive_load(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_cdb(0, 0, 0);
    chk("disp_capture_r1", EW'(data[0][EW-4 -: 32]), EW'(32'hAB));
    chk("disp_capture_rdy", EW'(ready[0]), EW'(1'b1));
    step();

    // Flush beats a concurrent load
    for (int i = 0; i < 3; i++) begin
      drive_load(1, 3'd2, 0, 0, 4'd15, 0, 1, 0, 4'(i));
      step();
    end
    flush = 1'b1;
    drive_load(1, 3'd3, 32'd1, 1, 0, 32'd2, 1, 0, 4'd6);
    step();
    flush = 1'b0;
    drive_load(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_count", EW'(count), EW'(0));
    step();

    // Asynchronous reset while an entry is ready
    drive_load(1, 3'd4, 32'd3, 1, 0, 32'd4, 1, 0, 4'd2);
    step();
    drive_load(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pre_rst_ready", EW'(ready), EW'(8'h01));
    rst = 1'b1;
    #1;
    m_reset();
    chk("rst_ready", EW'(ready), EW'(0));
    chk("rst_count", EW'(count), EW'(0));
    chk("rst_full", EW'(full), EW'(0));
    @(negedge clk);
    rst = 1'b0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive_load(($urandom % 3) != 0, 3'($urandom), $urandom, 1'($urandom), 4'($urandom),
                 $urandom, 1'($urandom), 4'($urandom), 4'($urandom));
      drive_cdb(1'($urandom), 4'($urandom), $urandom);
      flush = (($urandom % 40) == 0);
      step();
    end
    drive_load(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_cdb(0, 0, 0);
    flush = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cmp_rs.md
CMP_RS -- requirements
Module: cmp_rs

Interface
REQ-001 SHALL have parameter SIZE, default 8: number of compare reservation-station entries.
REQ-002 SHALL have parameter TAG_W, default 4: ROB tag width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1: discard all entries.
REQ-006 SHALL have port load, input, 1: dispatch valid.
REQ-007 SHALL have port in_op, input, 3: compare opcode (beq/bne/blt/bge/bltu/bgeu encoding).
REQ-008 SHALL have ports in_r1/in_r2, input, 32 each: operand value when valid.
REQ-009 SHALL have ports in_v1/in_v2, input, 1 each: operand already valid.
REQ-010 SHALL have ports in_q1/in_q2, input, TAG_W each: producer tag when not valid.
REQ-011 SHALL have port in_tag, input, TAG_W: destination ROB tag.
REQ-012 SHALL have ports cdb_valid (input, 1), cdb_tag (input, TAG_W) and cdb_data (input, 32): result broadcast bus.
REQ-013 SHALL have port data, output, SIZE x entry: per-entry opcode, r1, r2, tag, feeding the compare unit.
REQ-014 SHALL have port ready, output, SIZE: entry issuing to the compare unit this cycle.
REQ-015 SHALL have ports full (output, 1) and count (output, clog2(SIZE)+1): occupancy.

Function
REQ-016 Each entry SHALL hold valid, op, r1, v1, q1, r2, v2, q2, tag.
REQ-017 load with full low SHALL write the lowest-index free entry at the clock edge.
REQ-018 load with full high SHALL be ignored, with no state change.
REQ-019 full SHALL equal (count == SIZE), where count is the number of valid entries, both derived from registered state.
REQ-020 A slot freed by issue SHALL become allocatable only in the cycle after issue; there is no same-cycle reuse.
REQ-021 Wakeup: each valid entry with v1 low and cdb_valid high and cdb_tag == q1 SHALL latch r1 = cdb_data and v1 = 1; r2 follows the same rule.
REQ-022 A dispatching operand with in_v low and in_q == cdb_tag while cdb_valid is high SHALL be captured as valid at dispatch, so the broadcast is never missed.
REQ-023 When both operands match the same CDB tag, both SHALL be captured.
REQ-024 ready[i] SHALL equal valid[i] & v1[i] & v2[i], evaluated on registered state, except as modified by REQ-033.
REQ-025 Every ready entry SHALL issue in the same cycle, with no issue-width limit; its valid bit SHALL clear at the next edge.
REQ-026 ready SHALL be low for invalid entries; their data contents are don't-care but SHALL NOT produce X on ready.
REQ-027 flush SHALL clear all valid bits at the next edge and has priority over load and wakeup; ready SHALL remain per REQ-024 during the flush cycle.
REQ-028 Simultaneous load, wakeup, issue and free in one cycle SHALL all take effect independently at the same edge.

Reset
REQ-029 rst high SHALL asynchronously clear every valid, v1 and v2 bit.
REQ-030 While rst is high, ready SHALL be 0, full 0 and count 0.
REQ-031 Reset mid-operation SHALL drop all in-flight entries with no issue.
REQ-032 Payload fields (op, r1, r2, q1, q2, tag) SHALL NOT be required to reset.

Configuration
REQ-033 With macro CMP_RS_WAKEUP_BYPASS_EN defined, an entry whose last missing operand matches the CDB this cycle SHALL assert ready combinationally this cycle, with cdb_data forwarded on its data r1/r2 output, and SHALL free at the next edge.
REQ-034 With CMP_RS_WAKEUP_BYPASS_EN undefined, such an entry SHALL assert ready one cycle after the CDB broadcast, from registered operands only.

Verification
REQ-035 Reset, then load op=beq r1=5 r2=5 both valid, tag=3 -> ready[0]=1 the next cycle, data[0].tag=3; entry freed the cycle after, count back to 0.
REQ-036 Load r1 pending q1=7 with r2 valid; cdb_valid=1 tag=7 data=0x10 two cycles later -> r1 captured as 0x10; ready same cycle with the bypass macro defined, one cycle later without it.
REQ-037 Fill all 8 entries with pending operands -> full=1, count=8; a 9th load is ignored; one wakeup issues entry 4 -> the next load lands in index 4 one cycle after the issue.
REQ-038 Dispatch in_v1=0 in_q1=2 in the same cycle as cdb_tag=2 data=0xAB -> entry holds r1=0xAB, v1=1, with no missed wakeup.
REQ-039 Flush with load asserted and 3 entries valid -> count=0 next cycle, new entry not written; rst asserted mid-cycle -> ready drops to 0 immediately.
